// File: rtl/store_buffer_if.sv
// Bus bundle for store_buffer: MEM-stage store/load requests plus the unified memory port.
// The master side is the pipeline/memory environment; the slave side is the buffer.
interface store_buffer_if #(
  parameter int N = 64
);
  logic         st_valid;
  logic         st_ready;
  logic [1:0]   st_size;
  logic [N-1:0] st_adr;
  logic [N-1:0] st_data;

  logic         ld_valid;
  logic [N-1:0] ld_adr;
  logic         ld_dword;
  logic         ld_stall;
  logic [N-1:0] ld_data;

  logic [1:0]   mem_memwrite;
  logic [N-1:0] mem_dataadr;
  logic [N-1:0] mem_writedata;
  logic         mem_dword;
  logic [N-1:0] mem_readdata;

  modport master (
    output st_valid, st_size, st_adr, st_data,
    output ld_valid, ld_adr, ld_dword,
    output mem_readdata,
    input  st_ready, ld_stall, ld_data,
    input  mem_memwrite, mem_dataadr, mem_writedata, mem_dword
  );

  modport slave (
    input  st_valid, st_size, st_adr, st_data,
    input  ld_valid, ld_adr, ld_dword,
    input  mem_readdata,
    output st_ready, ld_stall, ld_data,
    output mem_memwrite, mem_dataadr, mem_writedata, mem_dword
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer sharing one memory port between draining stores and loads.
// Optional STB_FWD_EN: forward doubleword entries to overlapping loads instead of stalling.
module store_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  store_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  ptr_t             head;
  ptr_t             tail;
  ptr_t             idx;
  logic [DEPTH-1:0] ent_valid;
  logic [1:0]       ent_size [DEPTH];
  logic [N-1:0]     ent_adr  [DEPTH];
  logic [N-1:0]     ent_data [DEPTH];

  logic push;
  logic pop;
  logic hazard;
  logic load_owns;
  logic fwd;
`ifdef STB_FWD_EN
  logic [1:0]   fwd_size;
  logic [N-1:0] fwd_data;
`endif

  assign bus.st_ready = (count != FULL);
  assign empty        = (count == '0);
  assign push         = bus.st_valid && bus.st_ready && (bus.st_size != 2'd0);

  // Scan oldest to youngest so the last match is the youngest overlapping entry.
  always_comb begin
    hazard = 1'b0;
    idx    = head;
`ifdef STB_FWD_EN
    fwd_size = 2'd0;
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ent_valid[idx] && (ent_adr[idx][N-1:3] == bus.ld_adr[N-1:3])) begin
        hazard = bus.ld_valid;
`ifdef STB_FWD_EN
        fwd_size = ent_size[idx];
        fwd_data = ent_data[idx];
`endif
      end
    end
  end

`ifdef STB_FWD_EN
  assign fwd = hazard && (fwd_size == 2'd3);
`else
  assign fwd = 1'b0;
`endif

  assign load_owns = bus.ld_valid && !hazard;
  assign pop       = !load_owns && (count != '0);

  always_comb begin
    bus.mem_memwrite  = 2'd0;
    bus.mem_dataadr   = bus.ld_adr;
    bus.mem_writedata = '0;
    bus.mem_dword     = bus.ld_dword;
    bus.ld_stall      = hazard && !fwd;
    bus.ld_data       = bus.ld_dword ? bus.mem_readdata
                                     : {{(N-32){1'b0}}, bus.mem_readdata[31:0]};
    if (pop) begin
      bus.mem_memwrite  = ent_size[head];
      bus.mem_dataadr   = ent_adr[head];
      bus.mem_writedata = ent_data[head];
    end
`ifdef STB_FWD_EN
    if (fwd) begin
      if (bus.ld_dword)
        bus.ld_data = fwd_data;
      else
        bus.ld_data = {{(N-32){1'b0}}, bus.ld_adr[2] ? fwd_data[31:0] : fwd_data[32 +: 32]};
    end
`endif
  end

  // Push and pop never target the same slot: pop needs count > 0, push needs count < DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_size[tail] <= bus.st_size;
      ent_adr[tail]  <= bus.st_adr;
      ent_data[tail] <= bus.st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: fill/drain order, wrap, hazards, arbitration, reset.
// Forwarding expectations follow STB_FWD_EN when the bench is built with it.
module tb_store_buffer;
  localparam int N     = 64;
  localparam int DEPTH = 4;
  localparam logic [63:0] RD   = 64'hDEAD_BEEF_12AB_3456;
  localparam logic [63:0] RDW  = 64'h0000_0000_12AB_3456;

  logic clk;
  logic reset;
  logic [$clog2(DEPTH):0] count;
  logic empty;
  int checks;
  int errors;

  store_buffer_if #(.N(N)) sbif ();

  store_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sbif),
    .count (count),
    .empty (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Commit the previous cycle, drive the new one, then land on the falling edge for checks.
  task automatic applyStimulus(input logic stv, input logic [1:0] sz, input logic [63:0] sadr,
                               input logic [63:0] sdata, input logic ldv, input logic [63:0] ladr,
                               input logic ldw);
    @(posedge clk);
    #1;
    sbif.st_valid = stv;
    sbif.st_size  = sz;
    sbif.st_adr   = sadr;
    sbif.st_data  = sdata;
    sbif.ld_valid = ldv;
    sbif.ld_adr   = ladr;
    sbif.ld_dword = ldw;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    sbif.st_valid = 1'b0;
    sbif.st_size  = 2'd0;
    sbif.st_adr   = '0;
    sbif.st_data  = '0;
    sbif.ld_valid = 1'b0;
    sbif.ld_adr   = '0;
    sbif.ld_dword = 1'b0;
    sbif.mem_readdata = RD;
    #12;
    checkOutput("rst_st_ready", sbif.st_ready, 1);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_memwrite", sbif.mem_memwrite, 0);
    checkOutput("rst_ld_stall", sbif.ld_stall, 0);
    reset = 1'b1;

    // Illegal size is ignored
    applyStimulus(1, 2'd0, 64'h200, 64'h99, 0, 64'h0, 0);
    checkOutput("sz0_count_before", count, 0);

    // Fill with four D stores while an unrelated load owns the port
    applyStimulus(1, 2'd3, 64'h00, 64'hA0, 1, 64'h80, 0);
    checkOutput("sz0_ignored_count", count, 0);
    checkOutput("fill0_ld_stall", sbif.ld_stall, 0);
    applyStimulus(1, 2'd3, 64'h08, 64'hA1, 1, 64'h80, 0);
    checkOutput("fill1_count", count, 1);
    checkOutput("fill1_memwrite", sbif.mem_memwrite, 0);
    checkOutput("fill1_ld_data", sbif.ld_data, RDW);
    checkOutput("fill1_dataadr", sbif.mem_dataadr, 64'h80);
    applyStimulus(1, 2'd3, 64'h10, 64'hA2, 1, 64'h80, 0);
    checkOutput("fill2_count", count, 2);
    applyStimulus(1, 2'd3, 64'h18, 64'hA3, 1, 64'h80, 0);
    checkOutput("owns3_count", count, 3);
    checkOutput("owns3_memwrite", sbif.mem_memwrite, 0);
    checkOutput("owns3_ld_stall", sbif.ld_stall, 0);

    // Full: attempted push rejected while the head drains
    applyStimulus(1, 2'd3, 64'h28, 64'hB0, 0, 64'h0, 0);
    checkOutput("full_st_ready", sbif.st_ready, 0);
    checkOutput("full_count", count, 4);
    checkOutput("drain0_memwrite", sbif.mem_memwrite, 3);
    checkOutput("drain0_adr", sbif.mem_dataadr, 64'h00);
    checkOutput("drain0_data", sbif.mem_writedata, 64'hA0);
    applyStimulus(1, 2'd3, 64'h28, 64'hB0, 0, 64'h0, 0);
    checkOutput("drain1_st_ready", sbif.st_ready, 1);
    checkOutput("drain1_count", count, 3);
    checkOutput("drain1_adr", sbif.mem_dataadr, 64'h08);
    checkOutput("drain1_data", sbif.mem_writedata, 64'hA1);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 0, 64'h0, 0);
    checkOutput("pushpop_count", count, 3);
    checkOutput("drain2_adr", sbif.mem_dataadr, 64'h10);
    checkOutput("drain2_memwrite", sbif.mem_memwrite, 3);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 0, 64'h0, 0);
    checkOutput("drain3_count", count, 2);
    checkOutput("drain3_adr", sbif.mem_dataadr, 64'h18);
    checkOutput("drain3_data", sbif.mem_writedata, 64'hA3);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 0, 64'h0, 0);
    checkOutput("wrap_count", count, 1);
    checkOutput("wrap_adr", sbif.mem_dataadr, 64'h28);
    checkOutput("wrap_data", sbif.mem_writedata, 64'hB0);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 0, 64'h0, 0);
    checkOutput("drained_empty", empty, 1);
    checkOutput("drained_memwrite", sbif.mem_memwrite, 0);

    // Byte store then overlapping word load stalls until the byte drains
    applyStimulus(1, 2'd2, 64'h23, 64'hAB, 0, 64'h0, 0);
    checkOutput("bst_count", count, 0);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 1, 64'h20, 0);
    checkOutput("bhaz_ld_stall", sbif.ld_stall, 1);
    checkOutput("bhaz_memwrite", sbif.mem_memwrite, 2);
    checkOutput("bhaz_adr", sbif.mem_dataadr, 64'h23);
    checkOutput("bhaz_data", sbif.mem_writedata, 64'hAB);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 1, 64'h20, 0);
    checkOutput("bdone_ld_stall", sbif.ld_stall, 0);
    checkOutput("bdone_memwrite", sbif.mem_memwrite, 0);
    checkOutput("bdone_dataadr", sbif.mem_dataadr, 64'h20);
    checkOutput("bdone_ld_data", sbif.ld_data, RDW);
    checkOutput("bdone_dword", sbif.mem_dword, 0);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 1, 64'h20, 1);
    checkOutput("dld_ld_data", sbif.ld_data, RD);
    checkOutput("dld_dword", sbif.mem_dword, 1);

    // Doubleword store then word load to its upper address
    applyStimulus(1, 2'd3, 64'h40, 64'h1122334455667788, 0, 64'h0, 0);
    checkOutput("dst_count", count, 0);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 1, 64'h44, 0);
    checkOutput("dhaz_memwrite", sbif.mem_memwrite, 3);
    checkOutput("dhaz_adr", sbif.mem_dataadr, 64'h40);
`ifdef STB_FWD_EN
    checkOutput("fwd_ld_stall", sbif.ld_stall, 0);
    checkOutput("fwd_ld_data", sbif.ld_data, 64'h55667788);
`else
    checkOutput("nofwd_ld_stall", sbif.ld_stall, 1);
`endif
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 0, 64'h0, 0);
    checkOutput("dhaz_after_count", count, 0);

    // A store in the same cycle as a matching load is not a hazard yet
    applyStimulus(1, 2'd1, 64'h60, 64'hCAFE, 1, 64'h60, 0);
    checkOutput("same_ld_stall", sbif.ld_stall, 0);
    checkOutput("same_memwrite", sbif.mem_memwrite, 0);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 1, 64'h60, 0);
    checkOutput("whaz_ld_stall", sbif.ld_stall, 1);
    checkOutput("whaz_memwrite", sbif.mem_memwrite, 1);
    checkOutput("whaz_data", sbif.mem_writedata, 64'hCAFE);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 1, 64'h60, 0);
    checkOutput("whaz_done_stall", sbif.ld_stall, 0);

    // Reset with three entries pending
    applyStimulus(1, 2'd3, 64'h100, 64'hC0, 1, 64'h80, 0);
    applyStimulus(1, 2'd3, 64'h108, 64'hC1, 1, 64'h80, 0);
    applyStimulus(1, 2'd3, 64'h110, 64'hC2, 1, 64'h80, 0);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 1, 64'h80, 0);
    checkOutput("pre_rst_count", count, 3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_count", count, 0);
    checkOutput("async_rst_empty", empty, 1);
    checkOutput("async_rst_st_ready", sbif.st_ready, 1);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 0, 64'h0, 0);
    checkOutput("in_rst_memwrite", sbif.mem_memwrite, 0);
    #2;
    reset = 1'b1;
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 0, 64'h0, 0);
    checkOutput("post_rst_memwrite", sbif.mem_memwrite, 0);
    checkOutput("post_rst_count", count, 0);
    applyStimulus(0, 2'd0, 64'h0, 64'h0, 0, 64'h0, 0);
    checkOutput("post_rst_memwrite2", sbif.mem_memwrite, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
